// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch prefetch stage.
package if_pkg;
  localparam int FETCH_W = 32;
  localparam logic [FETCH_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_W-1:0] pc;
    logic [FETCH_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO of {pc, instr} with flush.
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     push_data,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage is data only; validity is carried entirely by count.
  always_ff @(posedge clk_in) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/if_prefetch.sv
// Fetch stage with a prefetch queue, credit-limited pipelined imem requests
// and redirect handling that discards responses still in flight.
module if_prefetch
  import if_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             redirect_in,
  input  logic [WIDTH-1:0] redirect_pc_in,
  output logic             imem_req_out,
  output logic [WIDTH-1:0] imem_addr_out,
  input  logic             imem_gnt_in,
  input  logic             imem_rvalid_in,
  input  logic [WIDTH-1:0] imem_rdata_in,
  output logic             id_valid_out,
  input  logic             id_ready_in,
  output logic [WIDTH-1:0] id_pc_out,
  output logic [WIDTH-1:0] id_instr_out
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] resp_pc;
  logic [WIDTH-1:0] target_pc;
  logic [CNT_W-1:0] outst_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W:0]   in_use;
  logic             grant;
  logic             resp;
  logic             push;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  assign target_pc = {redirect_pc_in[WIDTH-1:2], 2'b00};

  // Credit counts only registered occupancy, so every granted request has a slot.
  assign in_use        = {1'b0, q_count} + {1'b0, outst_cnt};
  assign imem_req_out  = rst_in && !redirect_in && (in_use < (CNT_W + 1)'(DEPTH));
  assign imem_addr_out = fetch_pc;
  assign grant         = imem_req_out && imem_gnt_in;

  // An rvalid with nothing outstanding is a bus error and is ignored.
  assign resp = imem_rvalid_in && (outst_cnt != '0);
  assign push = resp && (drop_cnt == '0) && !redirect_in;
  assign pop  = id_valid_out && id_ready_in && !redirect_in;

  assign push_entry.pc    = FETCH_W'(resp_pc);
  assign push_entry.instr = FETCH_W'(imem_rdata_in);

  assign id_valid_out = (q_count != '0);
  assign id_pc_out    = id_valid_out ? WIDTH'(head.pc) : '0;
  assign id_instr_out = id_valid_out ? WIDTH'(head.instr) : WIDTH'(NOP_INSTR);

  if_fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_in),
    .push_data (push_entry),
    .head      (head),
    .count     (q_count)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fetch_pc  <= RESET_PC;
      resp_pc   <= RESET_PC;
      outst_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      outst_cnt <= outst_cnt + CNT_W'(grant) - CNT_W'(resp);
      if (redirect_in) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        // Everything still in flight after this cycle belongs to the old path.
        drop_cnt <= outst_cnt - CNT_W'(resp);
      end else begin
        if (grant) fetch_pc <= fetch_pc + WIDTH'(4);
        if (push)  resp_pc  <= resp_pc + WIDTH'(4);
        if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

  a_no_orphan_rvalid: assert property (@(posedge clk_in) disable iff (!rst_in)
    !(imem_rvalid_in && (outst_cnt == '0)));
  a_credit_bound: assert property (@(posedge clk_in) disable iff (!rst_in)
    (drop_cnt <= outst_cnt) && (in_use <= (CNT_W + 1)'(DEPTH)));
endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: directed scenarios plus random traffic checked
// against a queue-based model of the fetch path and an in-order memory.
module tb_if_prefetch;
  localparam int DEPTH = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        redirect_in = 1'b0;
  logic [31:0] redirect_pc_in = '0;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in = 1'b0;
  logic        imem_rvalid_in = 1'b0;
  logic [31:0] imem_rdata_in = '0;
  logic        id_valid_out;
  logic        id_ready_in = 1'b0;
  logic [31:0] id_pc_out;
  logic [31:0] id_instr_out;

  if_prefetch #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .redirect_in    (redirect_in),
    .redirect_pc_in (redirect_pc_in),
    .imem_req_out   (imem_req_out),
    .imem_addr_out  (imem_addr_out),
    .imem_gnt_in    (imem_gnt_in),
    .imem_rvalid_in (imem_rvalid_in),
    .imem_rdata_in  (imem_rdata_in),
    .id_valid_out   (id_valid_out),
    .id_ready_in    (id_ready_in),
    .id_pc_out      (id_pc_out),
    .id_instr_out   (id_instr_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { logic [31:0] addr; int rdy_cyc; } mem_t;
  typedef struct { logic [31:0] addr; int epoch; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;

  mem_t        pend[$];
  flight_t     inflight[$];
  entry_t      mq[$];
  logic [31:0] delivered[$];
  logic [31:0] m_fetch;
  int          epoch;
  int          cyc;
  int          total;
  int          bad;
  logic        last_req;
  logic        last_valid;
  logic [31:0] last_addr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] first_delivered();
    return (delivered.size() != 0) ? delivered[0] : 32'hDEAD_BEEF;
  endfunction

  task automatic do_reset();
    rst_in = 1'b0;
    redirect_in = 1'b0;
    imem_gnt_in = 1'b0;
    imem_rvalid_in = 1'b0;
    id_ready_in = 1'b0;
    #1;
    chk("rst_req", imem_req_out, 0);
    chk("rst_valid", id_valid_out, 0);
    chk("rst_pc", id_pc_out, 32'h0);
    chk("rst_instr", id_instr_out, 32'h0000_0013);
    chk("rst_outst", u_dut.outst_cnt, 0);
    @(negedge clk_in);
    pend.delete();
    inflight.delete();
    mq.delete();
    delivered.delete();
    m_fetch = 32'h0;
    epoch = 0;
    rst_in = 1'b1;
  endtask

  // One clock: drive inputs at the falling edge, compare, advance model and memory.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy,
                      input bit gnt, input int rv_pct, input int dly_max);
    bit      rv;
    bit      m_req;
    bit      m_pop;
    int      stale;
    flight_t fl;
    redirect_in    = redir;
    redirect_pc_in = rpc;
    id_ready_in    = rdy;
    imem_gnt_in    = gnt;
    rv = (pend.size() != 0) && (pend[0].rdy_cyc <= cyc) && (int'($urandom_range(99)) < rv_pct);
    imem_rvalid_in = rv;
    imem_rdata_in  = rv ? instr_of(pend[0].addr) : $urandom();
    #1;
    m_req = !redir && (mq.size() + inflight.size() < DEPTH);
    stale = 0;
    foreach (inflight[i]) if (inflight[i].epoch != epoch) stale++;
    chk("req", imem_req_out, m_req);
    chk("addr", imem_addr_out, m_fetch);
    chk("valid", id_valid_out, mq.size() != 0);
    chk("pc", id_pc_out, (mq.size() != 0) ? mq[0].pc : 32'h0);
    chk("instr", id_instr_out, (mq.size() != 0) ? mq[0].instr : 32'h0000_0013);
    chk("outst", u_dut.outst_cnt, inflight.size());
    chk("drop", u_dut.drop_cnt, stale);
    last_req   = imem_req_out;
    last_valid = id_valid_out;
    last_addr  = imem_addr_out;
    if (id_valid_out && rdy && !redir) delivered.push_back(id_pc_out);
    if (rv) void'(pend.pop_front());
    if (imem_req_out && gnt)
      pend.push_back('{addr: imem_addr_out, rdy_cyc: cyc + 1 + int'($urandom_range(dly_max))});
    m_pop = (mq.size() != 0) && rdy;
    if (redir) begin
      mq.delete();
      epoch++;
      m_fetch = rpc & ~32'h3;
      if (rv && inflight.size() != 0) void'(inflight.pop_front());
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (rv && inflight.size() != 0) begin
        fl = inflight.pop_front();
        if (fl.epoch == epoch) mq.push_back('{pc: fl.addr, instr: instr_of(fl.addr)});
      end
      if (m_req && gnt) begin
        inflight.push_back('{addr: m_fetch, epoch: epoch});
        m_fetch = m_fetch + 32'd4;
      end
    end
    @(negedge clk_in);
    cyc++;
  endtask

  initial begin
    int first_v;
    int bubbles;
    logic [31:0] rpc;
    total = 0;
    bad = 0;
    cyc = 0;
    @(negedge clk_in);

    // Streaming: full-rate grants and 1-cycle memory.
    do_reset();
    first_v = -1;
    bubbles = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1, 100, 0);
      if (last_valid && first_v < 0) first_v = i;
      else if (!last_valid && first_v >= 0) bubbles++;
    end
    chk("first_valid_step", first_v, 2);
    chk("bubbles", bubbles, 0);
    for (int i = 0; i < 8; i++) chk("stream_pc", (delivered.size() > i) ? delivered[i] : 32'hDEAD_BEEF, 32'(i * 4));

    // Backpressure fills the queue and stops requests.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 100, 0);
    chk("full_req", last_req, 0);
    chk("full_valid", last_valid, 1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 100, 0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 100, 0);
    chk("resume_req", last_req, 1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 100, 0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 100, 0);
    for (int i = 0; i < 4; i++) chk("drain_pc", (delivered.size() > i) ? delivered[i] : 32'hDEAD_BEEF, 32'(i * 4));

    // Redirect with three requests outstanding.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 0, 0);
    step(1'b1, 32'h100, 1'b1, 1'b1, 0, 0);
    chk("drop3", u_dut.drop_cnt, 3);
    delivered.delete();
    for (int i = 0; i < 15; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 100, 0);
    chk("redir_first", first_delivered(), 32'h100);
    chk("redir_second", (delivered.size() > 1) ? delivered[1] : 32'hDEAD_BEEF, 32'h104);

    // Redirect colliding with rvalid and pop, two outstanding, unaligned target.
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1, 0, 0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 0, 0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 100, 0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 0, 0);
    step(1'b1, 32'h203, 1'b1, 1'b1, 100, 0);
    chk("redir_req", last_req, 0);
    chk("drop1", u_dut.drop_cnt, 1);
    delivered.delete();
    step(1'b0, 32'h0, 1'b1, 1'b1, 0, 0);
    chk("flush_valid", last_valid, 0);
    chk("align_addr", last_addr, 32'h200);
    for (int i = 0; i < 15; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 100, 0);
    chk("align_pc", first_delivered(), 32'h200);

    // Random traffic, including redirects near the top of the address space.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(15)) : $urandom();
      step($urandom_range(99) < 3, rpc, $urandom_range(99) < 70,
           $urandom_range(99) < 60, 70, 5);
      if (i == 1500) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
- Parametrised successor to the single-register fetch stage.
- Decouples PC generation from decode using a DEPTH-entry prefetch queue.
- Issues pipelined instruction-memory requests over a req/gnt/rvalid bus, with up to DEPTH transactions in flight.
- Branch/jump redirect flushes the queue and discards stale memory responses.
- Sits between the PC redirect source (EX stage) and ID; delivers {pc, instr} pairs to ID over a valid/ready handshake.

Parameters:
- WIDTH, 32, address and instruction width.
- DEPTH, 4, prefetch queue entries; also the maximum number of outstanding memory requests. Must be a power of 2, and at least 2.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  asynchronous, active-low reset.
- redirect_in  input  1  take branch/jump this cycle.
- redirect_pc_in  input  WIDTH  redirect target; bits [1:0] ignored and forced to 0.
- imem_req_out  output  1  memory request valid.
- imem_addr_out  output  WIDTH  request address.
- imem_gnt_in  input  1  request accepted (transfer = req & gnt).
- imem_rvalid_in  input  1  response valid; responses return in order, at least 1 cycle after grant.
- imem_rdata_in  input  WIDTH  response instruction.
- id_valid_out  output  1  queue head valid.
- id_ready_in  input  1  ID accepts the head.
- id_pc_out  output  WIDTH  PC of the head instruction.
- id_instr_out  output  WIDTH  head instruction.

Behaviour:
- Reset (rst_in=0, async):
  - fetch_pc = RESET_PC, resp_pc = RESET_PC.
  - Queue empty; outst_cnt = 0; drop_cnt = 0.
  - id_valid_out = 0, imem_req_out = 0, id_pc_out = 0, id_instr_out = NOP (32'h0000_0013).
- Counter widths: outst_cnt and drop_cnt are $clog2(DEPTH+1) bits. PC arithmetic is modulo 2^WIDTH; 32'hFFFF_FFFC+4 wraps to 0.
- Request issue (combinational):
  - imem_req_out = !redirect_in && (q_count + outst_cnt < DEPTH).
  - imem_addr_out = fetch_pc.
  - Credit uses registered counts only; a same-cycle pop does not free credit. The queue therefore can never overflow.
- Grant: on req & gnt, fetch_pc += 4 and outst_cnt increments.
- Withdrawal: req/addr may change any cycle without a grant; the memory must tolerate withdrawal.
- Response: on rvalid, outst_cnt decrements.
  - If drop_cnt > 0: discard the data and decrement drop_cnt.
  - Otherwise: push {resp_pc, rdata} and set resp_pc += 4.
  - Grant and rvalid in the same cycle leave outst_cnt unchanged.
- Output: id_valid_out = (q_count != 0). The head is popped on id_valid_out & id_ready_in. Push and pop in the same cycle keep q_count unchanged, including at full. When empty, id_pc_out and id_instr_out hold 0 and NOP.
- Redirect (redirect_in=1), highest priority:
  - Queue cleared; a same-cycle pop and push are discarded.
  - fetch_pc and resp_pc are set to {redirect_pc_in[WIDTH-1:2], 2'b00}.
  - drop_cnt is set to outst_cnt − imem_rvalid_in (every in-flight response is stale).
  - No request is issued that cycle.
  - Back-to-back redirects are legal; each recomputes drop_cnt the same way.
- Latency: first instruction is visible on id_valid_out one cycle after the rvalid that carries it (registered queue). Redirect to first new valid is at least 3 cycles with a 1-cycle memory.
- Invariants: drop_cnt ≤ outst_cnt ≤ DEPTH; q_count + outst_cnt ≤ DEPTH.
- Bus protocol errors: rvalid with outst_cnt = 0 is a protocol violation; the design ignores it and asserts in simulation.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight responses after reset release are not tracked (memory must also be reset).

Decomposition:
- Package if_pkg holds:
  - NOP_INSTR constant.
  - fetch_entry_t struct {pc, instr} parametrised by WIDTH via localparam.
- One sub-module: if_fetch_fifo, a synchronous FIFO with push/pop/flush, count output, DEPTH entries of fetch_entry_t, same clk_in/rst_in.
- Credit, drop and PC logic stay in if_prefetch.

Test Plan:
- Reset release, gnt always 1, 1-cycle rvalid, id_ready_in=1 → ID sees pc 0x0,0x4,0x8,… back-to-back, instr matching memory, no bubbles after fill.
- id_ready_in=0 with DEPTH=4 → after 4 grants imem_req_out drops; queue holds pc 0x0–0xC. Raise ready → pops in order and requests resume.
- Redirect to 0x100 while 3 requests are outstanding → the next 3 rvalids are discarded; first delivered entry is pc 0x100; no stale pc reaches ID.
- Redirect in the same cycle as rvalid and pop, with outst_cnt=2 → drop_cnt=1; queue empty next cycle; imem_req_out=0 during the redirect cycle.
- redirect_pc_in=0x203 → next imem_addr_out=0x200 and id_pc_out=0x200.
- Random gnt and rvalid delays (0–5 cycles), random ready and redirects against a reference PC model → every delivered pc/instr pair matches; invariants hold every cycle.
